// File: rtl/sdf_frame_ctrl_pkg.sv
// Shared definitions for the SDF frame controller: default FFT geometry,
// FSM state encoding and the bin-index bit-reverse helper.
package sdf_frame_ctrl_pkg;

    localparam int C2LOG_FFT_POINTS = 4;
    localparam int DATA_IN_WIDTH    = 16;
    localparam int BITREV_MAX       = 16;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } sdf_state_e;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [BITREV_MAX-1:0] bit_rev(input logic [BITREV_MAX-1:0] v,
                                                      input int w);
        logic [BITREV_MAX-1:0] r;
        logic [BITREV_MAX-1:0] t;
        r = {BITREV_MAX{1'b0}};
        t = v;
        for (int i = 0; i < BITREV_MAX; i++) begin
            if (i < w) begin
                r = {r[BITREV_MAX-2:0], t[0]};
                t = {1'b0, t[BITREV_MAX-1:1]};
            end else begin
                r = r;
                t = t;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sdf_frame_ctrl_if.sv
// Signal bundle between the frame controller and its environment: sample
// input stream, pipeline di/do ports, framed output stream and status.
interface sdf_frame_ctrl_if #(
    parameter int LOG2N = sdf_frame_ctrl_pkg::C2LOG_FFT_POINTS,
    parameter int DW    = sdf_frame_ctrl_pkg::DATA_IN_WIDTH
);
    logic             enable;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_re;
    logic [DW-1:0]    in_im;
    logic             fft_di_en;
    logic [DW-1:0]    fft_di_re;
    logic [DW-1:0]    fft_di_im;
    logic             fft_do_en;
    logic [DW-1:0]    fft_do_re;
    logic [DW-1:0]    fft_do_im;
    logic             out_valid;
    logic [DW-1:0]    out_re;
    logic [DW-1:0]    out_im;
    logic             out_sop;
    logic             out_eop;
    logic [LOG2N-1:0] out_idx;
    logic [15:0]      frame_cnt;
    logic             busy;
    logic             err_gap;

    // Controller view.
    modport slave (
        input  enable, flush, in_valid, in_re, in_im,
        input  fft_do_en, fft_do_re, fft_do_im,
        output in_ready, fft_di_en, fft_di_re, fft_di_im,
        output out_valid, out_re, out_im, out_sop, out_eop, out_idx,
        output frame_cnt, busy, err_gap
    );

    // Environment view.
    modport master (
        output enable, flush, in_valid, in_re, in_im,
        output fft_do_en, fft_do_re, fft_do_im,
        input  in_ready, fft_di_en, fft_di_re, fft_di_im,
        input  out_valid, out_re, out_im, out_sop, out_eop, out_idx,
        input  frame_cnt, busy, err_gap
    );
endinterface

// File: rtl/sdf_frame_fifo.sv
// Single-clock FIFO with occupancy count. Read data is show-ahead (head
// entry visible combinationally). clr empties the FIFO and drops a
// concurrent push.
module sdf_frame_fifo #(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   fill,
    output logic          full
);
    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem_r [0:DEPTH-1];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   fill_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (fill_r == FILL_MAX);
    assign do_push_s = push & ~full & ~clr;
    assign do_pop_s  = pop & (fill_r != {(AW+1){1'b0}}) & ~clr;
    assign rd_data   = mem_r[rd_ptr_r];
    assign fill      = fill_r;

    // Pointer and occupancy bookkeeping; push+pop together keeps fill.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            fill_r   <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({do_push_s, do_pop_s})
                2'b10:   fill_r <= fill_r + FILL_ONE;
                2'b01:   fill_r <= fill_r - FILL_ONE;
                default: fill_r <= fill_r;
            endcase
        end
    end

    // Sample storage.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
    end
endmodule

// File: rtl/sdf_frame_ctrl.sv
// Frame scheduler in front of the R2SDF pipeline and output framer behind
// it. Only complete N-point frames are launched, as gapless di_en bursts,
// since the SDF stage counters restart whenever di_en drops.
module sdf_frame_ctrl
    import sdf_frame_ctrl_pkg::*;
#(
    parameter int LOG2N   = C2LOG_FFT_POINTS,
    parameter int DW      = DATA_IN_WIDTH,
    parameter int FIFO_AW = LOG2N + 1
) (
    input logic            clk,
    input logic            rst,
    sdf_frame_ctrl_if.slave bus
);
    localparam int               N          = 1 << LOG2N;
    localparam logic [FIFO_AW:0] N_FILL     = (FIFO_AW+1)'(N);
    localparam logic [FIFO_AW:0] FILL_ONE   = (FIFO_AW+1)'(1);
    localparam logic [LOG2N-1:0] CNT_LAST   = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] CNT_ONE    = LOG2N'(1);
    localparam logic [LOG2N:0]   FLIGHT_MAX = (LOG2N+1)'(N);
    localparam logic [LOG2N:0]   FLIGHT_ONE = (LOG2N+1)'(1);

    sdf_state_e       state_r;
    logic [LOG2N-1:0] cnt_r;
    logic [LOG2N:0]   in_flight_r;
    logic [LOG2N-1:0] ocnt_r;
    logic             di_en_r;
    logic [DW-1:0]    di_re_r;
    logic [DW-1:0]    di_im_r;
    logic             out_valid_r;
    logic [DW-1:0]    out_re_r;
    logic [DW-1:0]    out_im_r;
    logic             out_sop_r;
    logic             out_eop_r;
    logic [LOG2N-1:0] out_idx_r;
    logic [15:0]      frame_cnt_r;
    logic             err_gap_r;

    logic [FIFO_AW:0]      fill_s;
    logic [FIFO_AW:0]      fill_after_pop_s;
    logic                  full_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  clr_s;
    logic [2*DW-1:0]       rd_data_s;
    logic                  launch_s;
    logic                  eop_s;
    logic [BITREV_MAX-1:0] idx_wide_s;
    logic [BITREV_MAX-LOG2N-1:0] unused_idx_hi_s;

    // Flush only acts while idle so an in-progress burst is never starved.
    assign clr_s            = bus.flush & (state_r == ST_IDLE);
    assign push_s           = bus.in_valid & ~full_s;
    assign pop_s            = (state_r == ST_STREAM);
    assign fill_after_pop_s = fill_s - FILL_ONE + {{FIFO_AW{1'b0}}, push_s};
    assign eop_s            = bus.fft_do_en & (ocnt_r == CNT_LAST);
    assign idx_wide_s       = bit_rev(BITREV_MAX'(ocnt_r), LOG2N);
    assign unused_idx_hi_s  = idx_wide_s[BITREV_MAX-1:LOG2N];

    sdf_frame_fifo #(
        .W  (2*DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_s),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data ({bus.in_re, bus.in_im}),
        .rd_data (rd_data_s),
        .fill    (fill_s),
        .full    (full_s)
    );

    // Launch decision: a full frame must already be buffered, both for a
    // fresh start and for chaining straight into the next frame.
    always_comb begin
        launch_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.enable && !bus.flush && (fill_s >= N_FILL)) launch_s = 1'b1;
                else launch_s = 1'b0;
            end
            ST_STREAM: begin
                if ((cnt_r == CNT_LAST) && bus.enable && (fill_after_pop_s >= N_FILL)) launch_s = 1'b1;
                else launch_s = 1'b0;
            end
            default: launch_s = 1'b0;
        endcase
    end

    // Launch FSM: streams N FIFO pops per frame onto the registered di port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {LOG2N{1'b0}};
            di_en_r <= 1'b0;
            di_re_r <= {DW{1'b0}};
            di_im_r <= {DW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    di_en_r <= 1'b0;
                    di_re_r <= {DW{1'b0}};
                    di_im_r <= {DW{1'b0}};
                    cnt_r   <= {LOG2N{1'b0}};
                    state_r <= launch_s ? ST_STREAM : ST_IDLE;
                end
                ST_STREAM: begin
                    di_en_r <= 1'b1;
                    di_re_r <= rd_data_s[2*DW-1:DW];
                    di_im_r <= rd_data_s[DW-1:0];
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= {LOG2N{1'b0}};
                        state_r <= launch_s ? ST_STREAM : ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= ST_STREAM;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {LOG2N{1'b0}};
                    di_en_r <= 1'b0;
                    di_re_r <= {DW{1'b0}};
                    di_im_r <= {DW{1'b0}};
                end
            endcase
        end
    end

    // Frames launched but not yet seen at the output; saturating both ways.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight_r <= {(LOG2N+1){1'b0}};
        end else if (launch_s && !eop_s) begin
            if (in_flight_r != FLIGHT_MAX) in_flight_r <= in_flight_r + FLIGHT_ONE;
        end else if (eop_s && !launch_s) begin
            if (in_flight_r != {(LOG2N+1){1'b0}}) in_flight_r <= in_flight_r - FLIGHT_ONE;
        end else begin
            in_flight_r <= in_flight_r;
        end
    end

    // Output framer: sop/eop, bit-reversed bin index, frame count, gap flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ocnt_r      <= {LOG2N{1'b0}};
            out_valid_r <= 1'b0;
            out_re_r    <= {DW{1'b0}};
            out_im_r    <= {DW{1'b0}};
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
            out_idx_r   <= {LOG2N{1'b0}};
            frame_cnt_r <= 16'd0;
            err_gap_r   <= 1'b0;
        end else begin
            out_valid_r <= bus.fft_do_en;
            out_re_r    <= bus.fft_do_re;
            out_im_r    <= bus.fft_do_im;
            if (bus.fft_do_en) begin
                out_sop_r <= (ocnt_r == {LOG2N{1'b0}});
                out_eop_r <= eop_s;
                out_idx_r <= idx_wide_s[LOG2N-1:0];
                ocnt_r    <= ocnt_r + CNT_ONE;
            end else begin
                out_sop_r <= 1'b0;
                out_eop_r <= 1'b0;
                out_idx_r <= {LOG2N{1'b0}};
                // A drop mid-frame breaks the frame: flag it and resync.
                if (ocnt_r != {LOG2N{1'b0}}) begin
                    err_gap_r <= 1'b1;
                    ocnt_r    <= {LOG2N{1'b0}};
                end
            end
            if (eop_s) frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end

    assign bus.in_ready  = ~full_s;
    assign bus.fft_di_en = di_en_r;
    assign bus.fft_di_re = di_re_r;
    assign bus.fft_di_im = di_im_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_re    = out_re_r;
    assign bus.out_im    = out_im_r;
    assign bus.out_sop   = out_sop_r;
    assign bus.out_eop   = out_eop_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.frame_cnt = frame_cnt_r;
    assign bus.busy      = (state_r != ST_IDLE) || (in_flight_r != {(LOG2N+1){1'b0}});
    assign bus.err_gap   = err_gap_r;
endmodule

// File: tb/tb_sdf_frame_ctrl.sv
// Bench for sdf_frame_ctrl (N=16, FIFO depth 32). A queue-based model of
// frame launching and output framing is compared against the DUT on every
// negative edge; directed tests add literal expectations.
module tb_sdf_frame_ctrl;
    localparam int LOG2N = 4;
    localparam int N     = 16;
    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    sdf_frame_ctrl_if #(.LOG2N(LOG2N), .DW(DW)) bus();

    sdf_frame_ctrl #(.LOG2N(LOG2N), .DW(DW), .FIFO_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // model state
    logic [31:0] q[$];
    int          rem = 0;
    int          m_inflight = 0;
    int          m_ocnt = 0;
    int          m_launches = 0;
    logic [15:0] m_frames = 16'd0;
    logic        m_err = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] e_ready, e_di_en, e_di_re, e_di_im, e_oval, e_ore, e_oim;
    logic [31:0] e_sop, e_eop, e_idx, e_busy;

    // captures
    int di_q[$];
    int bursts[$];
    int cur_len = 0;
    int o_idx[$];
    int o_sop[$];
    int o_eop[$];

    int idx_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic int rev4(input int p);
        return ((p & 1) << 3) | ((p & 2) << 1) | ((p & 4) >> 1) | ((p & 8) >> 3);
    endfunction

    // compare, capture, then advance the model with the inputs the next edge samples
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("in_ready",  32'(bus.in_ready),  e_ready);
                check("di_en",     32'(bus.fft_di_en), e_di_en);
                check("di_re",     32'(bus.fft_di_re), e_di_re);
                check("di_im",     32'(bus.fft_di_im), e_di_im);
                check("out_valid", 32'(bus.out_valid), e_oval);
                if (e_oval[0]) begin
                    check("out_re", 32'(bus.out_re), e_ore);
                    check("out_im", 32'(bus.out_im), e_oim);
                end
                check("out_sop",   32'(bus.out_sop),   e_sop);
                check("out_eop",   32'(bus.out_eop),   e_eop);
                check("out_idx",   32'(bus.out_idx),   e_idx);
                check("frame_cnt", 32'(bus.frame_cnt), {16'd0, m_frames});
                check("busy",      32'(bus.busy),      e_busy);
                check("err_gap",   32'(bus.err_gap),   32'(m_err));
            end
            if (bus.fft_di_en === 1'b1) begin
                di_q.push_back(int'(bus.fft_di_re));
                cur_len++;
            end else if (cur_len > 0) begin
                bursts.push_back(cur_len);
                cur_len = 0;
            end
            if (bus.out_valid === 1'b1) begin
                o_idx.push_back(int'(bus.out_idx));
                o_sop.push_back(int'(bus.out_sop));
                o_eop.push_back(int'(bus.out_eop));
            end
            if (rst) begin
                q.delete();
                rem = 0; m_inflight = 0; m_ocnt = 0; m_frames = 16'd0; m_err = 1'b0;
                e_ready = 32'd1; e_di_en = 32'd0; e_di_re = 32'd0; e_di_im = 32'd0;
                e_oval = 32'd0; e_ore = 32'd0; e_oim = 32'd0; e_sop = 32'd0; e_eop = 32'd0;
                e_idx = 32'd0; e_busy = 32'd0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                bit push, launch, eop;
                logic [31:0] w;
                push = bus.in_valid && (q.size() != DEPTH);
                launch = 1'b0;
                e_di_en = 32'd0; e_di_re = 32'd0; e_di_im = 32'd0;
                if (rem > 0) begin
                    w = q.pop_front();
                    e_di_en = 32'd1; e_di_re = {16'd0, w[31:16]}; e_di_im = {16'd0, w[15:0]};
                    rem--;
                    if (rem == 0 && bus.enable && (q.size() + int'(push)) >= N) begin
                        rem = N; launch = 1'b1;
                    end
                    if (push) q.push_back({bus.in_re, bus.in_im});
                end else if (bus.flush) begin
                    q.delete();
                end else begin
                    if (bus.enable && q.size() >= N) begin
                        rem = N; launch = 1'b1;
                    end
                    if (push) q.push_back({bus.in_re, bus.in_im});
                end
                if (launch) m_launches++;
                eop = 1'b0;
                e_oval = 32'(bus.fft_do_en);
                e_sop = 32'd0; e_eop = 32'd0; e_idx = 32'd0;
                if (bus.fft_do_en) begin
                    e_ore = 32'(bus.fft_do_re); e_oim = 32'(bus.fft_do_im);
                    e_sop = 32'(m_ocnt == 0);
                    e_eop = 32'(m_ocnt == N - 1);
                    e_idx = 32'(rev4(m_ocnt));
                    eop = (m_ocnt == N - 1);
                    m_ocnt = (m_ocnt + 1) % N;
                end else if (m_ocnt != 0) begin
                    m_err = 1'b1; m_ocnt = 0;
                end
                if (eop) m_frames = m_frames + 16'd1;
                if (launch && !eop) begin
                    if (m_inflight < N) m_inflight++;
                end else if (eop && !launch) begin
                    if (m_inflight > 0) m_inflight--;
                end
                e_busy = 32'((rem > 0) || (m_inflight > 0));
                e_ready = 32'(q.size() != DEPTH);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            bus.in_valid = 1'b1;
            bus.in_re = 16'(base + k);
            bus.in_im = 16'(-(base + k));
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drive_do(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            bus.fft_do_en = 1'b1;
            bus.fft_do_re = 16'(base + k);
            bus.fft_do_im = 16'(k);
            tick();
        end
        bus.fft_do_en = 1'b0;
    endtask

    task automatic wait_bursts(input int n, input int budget, input string nm);
        int c = 0;
        while (bursts.size() < n && c < budget) begin
            tick();
            c++;
        end
        check(nm, 32'(bursts.size()), 32'(n));
    endtask

    task automatic clear_caps();
        di_q.delete(); bursts.delete(); o_idx.delete(); o_sop.delete(); o_eop.delete();
    endtask

    task automatic check_di(input string nm, input int len, input int base);
        check(nm, 32'(di_q.size()), 32'(len));
        for (int i = 0; i < len && i < di_q.size(); i++) check(nm, 32'(di_q[i]), 32'(base + i));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, s;
        rst = 1'b1;
        bus.enable = 1'b0; bus.flush = 1'b0;
        bus.in_valid = 1'b1; bus.in_re = 16'h1234; bus.in_im = 16'h5678;
        bus.fft_do_en = 1'b0; bus.fft_do_re = 16'd0; bus.fft_do_im = 16'd0;
        repeat (3) tick();
        rst = 1'b0; bus.in_valid = 1'b0;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_di_en",     32'(bus.fft_di_en), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        check("rst_err_gap",   32'(bus.err_gap),   32'd0);
        tick();

        // single launch
        clear_caps();
        l0 = m_launches;
        push_n(16, 0);
        check("no_launch_disabled", 32'(di_q.size()), 32'd0);
        bus.enable = 1'b1;
        wait_bursts(1, 40, "launch_burst_seen");
        check("launch_burst_len", 32'(bursts.size() > 0 ? bursts[0] : 0), 32'd16);
        check_di("launch_data", 16, 0);
        check("launch_count", 32'(m_launches - l0), 32'd1);
        repeat (3) tick();
        bus.enable = 1'b0;

        // back-to-back frames
        clear_caps();
        l0 = m_launches;
        bus.enable = 1'b1;
        push_n(48, 300);
        wait_bursts(1, 100, "b2b_burst_seen");
        repeat (5) tick();
        check("b2b_burst_count", 32'(bursts.size()), 32'd1);
        check("b2b_burst_len", 32'(bursts.size() > 0 ? bursts[0] : 0), 32'd48);
        check_di("b2b_data", 48, 300);
        check("b2b_launches", 32'(m_launches - l0), 32'd3);
        bus.enable = 1'b0;

        // underfill, then flush with a concurrent push, then a clean frame
        clear_caps();
        bus.enable = 1'b1;
        push_n(15, 500);
        repeat (10) tick();
        check("underfill_no_launch", 32'(bursts.size() + cur_len), 32'd0);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_re = 16'd999; bus.in_im = 16'd999;
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        tick();
        push_n(16, 600);
        wait_bursts(1, 40, "flush_burst_seen");
        check("flush_burst_len", 32'(bursts.size() > 0 ? bursts[0] : 0), 32'd16);
        check_di("flush_data", 16, 600);
        repeat (3) tick();
        bus.enable = 1'b0;

        // output framing
        clear_caps();
        drive_do(16, 200);
        repeat (3) tick();
        check("frm_samples", 32'(o_idx.size()), 32'd16);
        s = 0;
        for (int i = 0; i < 16 && i < o_idx.size(); i++) begin
            check("frm_idx", 32'(o_idx[i]), 32'(idx_tab[i]));
            s += o_sop[i] + o_eop[i];
        end
        check("frm_sop_first", 32'(o_sop.size() > 0 ? o_sop[0] : 0), 32'd1);
        check("frm_eop_last", 32'(o_eop.size() > 15 ? o_eop[15] : 0), 32'd1);
        check("frm_marker_total", 32'(s), 32'd2);
        check("frm_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        check("frm_err_gap", 32'(bus.err_gap), 32'd0);

        // gap error, then a restart from sop
        drive_do(5, 40);
        repeat (3) tick();
        check("gap_err_set", 32'(bus.err_gap), 32'd1);
        clear_caps();
        drive_do(16, 60);
        repeat (2) tick();
        check("gap_restart_sop", 32'(o_sop.size() > 0 ? o_sop[0] : 0), 32'd1);
        check("gap_restart_idx", 32'(o_idx.size() > 0 ? o_idx[0] : 99), 32'd0);
        check("gap_err_sticky", 32'(bus.err_gap), 32'd1);
        check("gap_frame_cnt", 32'(bus.frame_cnt), 32'd2);

        // drain remaining in-flight frames, then one eop with nothing in flight
        for (int f = 0; f < 3; f++) begin
            drive_do(16, 80 + f);
            tick();
        end
        tick();
        check("drain_busy", 32'(bus.busy), 32'd0);
        check("drain_frame_cnt", 32'(bus.frame_cnt), 32'd5);
        drive_do(16, 7);
        repeat (2) tick();
        check("underflow_busy", 32'(bus.busy), 32'd0);
        check("underflow_frame_cnt", 32'(bus.frame_cnt), 32'd6);
        check("final_err_gap", 32'(bus.err_gap), 32'd1);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
